// File: rtl/systolic_array_ctrl_if.sv
// Command/status and feeder-control bundle between the host, the sequencer and the array datapath.
// The host drives start/k_len/abort; the sequencer drives everything else.
interface systolic_array_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 8
);
    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic          arr_clr;
    logic          feed_en;
    logic [KW:0]   k_idx;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;
    logic          capture;

    modport master (
        output start, k_len, abort,
        input  busy, done, err, arr_clr, feed_en, k_idx, row_en, col_en, capture
    );

    modport slave (
        input  start, k_len, abort,
        output busy, done, err, arr_clr, feed_en, k_idx, row_en, col_en, capture
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Pass sequencer for an N x N systolic array: clear, skewed operand feed, pipeline drain, capture.
// Every output comes straight from a flop; the next values are decoded from the next state.
module systolic_array_ctrl #(
    parameter int N     = 4,
    parameter int KW    = 8,
    parameter int DRAIN = N + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    systolic_array_ctrl_if.slave bus
);
    localparam int DW = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] kLen_q, kLen_d;
    logic [KW:0]   t_q, t_d;
    logic [DW-1:0] drainCnt_q, drainCnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          arrClr_q, arrClr_d;
    logic          feedEn_q, feedEn_d;
    logic          capture_q, capture_d;
    logic [N-1:0]  laneEn_q, laneEn_d;
    logic [KW:0]   lastT;

    // Final feed step is K+N-2: the last lane sees its last element N-1 steps after lane 0.
    assign lastT = {1'b0, kLen_q} + (KW+1)'(N - 2);

    always_comb begin
        state_d    = state_q;
        kLen_d     = kLen_q;
        t_d        = t_q;
        drainCnt_d = drainCnt_q;
        err_d      = 1'b0;
        laneEn_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != '0) begin
                        kLen_d  = bus.k_len;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                t_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (t_q == lastT) begin
                    drainCnt_d = '0;
                    state_d    = S_DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drainCnt_q == DW'(DRAIN - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    drainCnt_d = drainCnt_q + 1'b1;
                end
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Abort wins over everything; array contents are left for the next CLEAR.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end

        busy_d    = (state_d != S_IDLE);
        arrClr_d  = (state_d == S_CLEAR);
        feedEn_d  = (state_d == S_FEED);
        capture_d = (state_d == S_CAPTURE);
        done_d    = (state_d == S_DONE);

        // Lane i is valid while its skewed index t-i lies inside 0..K-1.
        for (int i = 0; i < N; i++) begin
            if (state_d == S_FEED && t_d >= (KW+1)'(i) &&
                (t_d - (KW+1)'(i)) < {1'b0, kLen_d}) begin
                laneEn_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            kLen_q     <= '0;
            t_q        <= '0;
            drainCnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            arrClr_q   <= 1'b0;
            feedEn_q   <= 1'b0;
            capture_q  <= 1'b0;
            laneEn_q   <= '0;
        end else begin
            state_q    <= state_d;
            kLen_q     <= kLen_d;
            t_q        <= t_d;
            drainCnt_q <= drainCnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            arrClr_q   <= arrClr_d;
            feedEn_q   <= feedEn_d;
            capture_q  <= capture_d;
            laneEn_q   <= laneEn_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.arr_clr = arrClr_q;
    assign bus.feed_en = feedEn_q;
    assign bus.capture = capture_q;
    assign bus.k_idx   = t_q;
    assign bus.row_en  = laneEn_q;
    assign bus.col_en  = laneEn_q;
endmodule
